// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter
//  Purpose  : Round-robin merge of two write-back sources (ALU, load/CSR),
//             each behind its own small FIFO, onto the single rf write port.
//  Revision : 1.0  initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int ALEN       = 5,
  parameter int DLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_a_valid,
  output logic            o_a_ready,
  input  logic [ALEN-1:0] i_a_addr,
  input  logic [DLEN-1:0] i_a_data,
  input  logic            i_b_valid,
  output logic            o_b_ready,
  input  logic [ALEN-1:0] i_b_addr,
  input  logic [DLEN-1:0] i_b_data,
  output logic            o_wen,
  output logic [ALEN-1:0] o_waddr,
  output logic [DLEN-1:0] o_wdata,
  output logic            o_busy
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(FIFO_DEPTH - 1);
  localparam logic c_src_a = 1'b0;
  localparam logic c_src_b = 1'b1;

  // Index 0 is source A, index 1 is source B throughout.
  logic [1:0]      w_in_valid;
  logic [ALEN-1:0] w_in_addr [2];
  logic [DLEN-1:0] w_in_data [2];
  logic [1:0]      w_full;
  logic [1:0]      w_empty;
  logic [1:0]      w_ready;
  logic [1:0]      w_pop;
  logic [ALEN-1:0] w_head_addr [2];
  logic [DLEN-1:0] w_head_data [2];

  logic            r_rr_last;
  logic            r_wen;
  logic [ALEN-1:0] r_waddr;
  logic [DLEN-1:0] r_wdata;

  assign w_in_valid   = {i_b_valid, i_a_valid};
  assign w_in_addr[0] = i_a_addr;
  assign w_in_addr[1] = i_b_addr;
  assign w_in_data[0] = i_a_data;
  assign w_in_data[1] = i_b_data;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_fifo
      logic [ALEN-1:0]    r_addr_mem [FIFO_DEPTH];
      logic [DLEN-1:0]    r_data_mem [FIFO_DEPTH];
      logic [c_ptr_w-1:0] r_wptr;
      logic [c_ptr_w-1:0] r_rptr;
      logic [c_cnt_w-1:0] r_count;
      logic               w_push;

      // Readiness comes from occupancy alone, so a full FIFO refuses even
      // when it is being popped on the same edge.
      assign w_full[g]      = (r_count == c_full);
      assign w_empty[g]     = (r_count == '0);
      assign w_ready[g]     = !rst && !w_full[g];
      assign w_push         = w_in_valid[g] && w_ready[g];
      assign w_head_addr[g] = r_addr_mem[r_rptr];
      assign w_head_data[g] = r_data_mem[r_rptr];

      always_ff @(posedge clk) begin
        if (w_push) begin
          r_addr_mem[r_wptr] <= w_in_addr[g];
          r_data_mem[r_wptr] <= w_in_data[g];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
        end else begin
          if (w_push) begin
            r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
          end
          if (w_pop[g]) begin
            r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
          end
          case ({w_push, w_pop[g]})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  // On a tie the source that did not win last time goes next.
  always_comb begin
    w_pop    = 2'b00;
    w_pop[0] = !w_empty[0] && (w_empty[1] || (r_rr_last == c_src_b));
    w_pop[1] = !w_empty[1] && (w_empty[0] || (r_rr_last == c_src_a));
  end

  logic            w_sel;
  logic [ALEN-1:0] w_sel_addr;
  logic            w_drop;

  assign w_sel      = w_pop[1];
  assign w_sel_addr = w_head_addr[w_sel];
  assign w_drop     = (ZERO_REG != 0) && (w_sel_addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_rr_last <= c_src_b;
    end else if (|w_pop) begin
      r_wen     <= !w_drop;
      r_waddr   <= w_sel_addr;
      r_wdata   <= w_head_data[w_sel];
      r_rr_last <= w_sel;
    end else begin
      r_wen <= 1'b0;
    end
  end

  assign o_a_ready = w_ready[0];
  assign o_b_ready = w_ready[1];
  assign o_wen     = r_wen;
  assign o_waddr   = r_waddr;
  assign o_wdata   = r_wdata;
  assign o_busy    = !(&w_empty) || r_wen;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_wb_arbiter
//  Purpose  : Directed and randomized checks of rf_wb_arbiter against a
//             queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_wb_arbiter;

  localparam int c_depth = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_a_valid = 1'b0;
  logic        o_a_ready;
  logic [4:0]  i_a_addr = '0;
  logic [31:0] i_a_data = '0;
  logic        i_b_valid = 1'b0;
  logic        o_b_ready;
  logic [4:0]  i_b_addr = '0;
  logic [31:0] i_b_data = '0;
  logic        o_wen;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic        o_busy;

  rf_wb_arbiter #(
    .ALEN(5), .DLEN(32), .FIFO_DEPTH(c_depth), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_addr(i_a_addr), .i_a_data(i_a_data),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_addr(i_b_addr), .i_b_data(i_b_data),
    .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: each queue entry is {addr, data}.
  logic [36:0] q_a[$];
  logic [36:0] q_b[$];
  logic        m_rr_b  = 1'b1;
  logic        m_wen   = 1'b0;
  logic [4:0]  m_addr  = '0;
  logic [31:0] m_data  = '0;
  logic [31:0] rf_exp [32];
  logic [31:0] rf_obs [32];
  logic [31:0] b_log[$];
  logic        acc_b;
  logic        saw_b_stall = 1'b0;

  always @(posedge clk) begin
    if (o_wen) rf_obs[o_waddr] <= o_wdata;
    if (o_wen && o_waddr == 5'd7) b_log.push_back(o_wdata);
  end

  // One cycle: drive at negedge, check pre-edge outputs, advance model,
  // check registered outputs after the edge.
  task automatic step(input logic r, input logic va, input logic [4:0] aa, input logic [31:0] da,
                      input logic vb, input logic [4:0] ab, input logic [31:0] db);
    logic       rdy_a, rdy_b, pa, pb;
    logic [36:0] e;
    rst = r; i_a_valid = va; i_a_addr = aa; i_a_data = da;
    i_b_valid = vb; i_b_addr = ab; i_b_data = db;
    #1;
    rdy_a = !r && (q_a.size() < c_depth);
    rdy_b = !r && (q_b.size() < c_depth);
    chk("a_ready", o_a_ready, rdy_a);
    chk("b_ready", o_b_ready, rdy_b);
    chk("busy", o_busy, (q_a.size() != 0) || (q_b.size() != 0) || m_wen);
    if (vb && !o_b_ready) saw_b_stall = 1'b1;
    acc_b = vb && rdy_b;
    if (r) begin
      q_a.delete(); q_b.delete();
      m_wen = 1'b0; m_addr = '0; m_data = '0; m_rr_b = 1'b1;
    end else begin
      pa = (q_a.size() != 0) && ((q_b.size() == 0) || m_rr_b);
      pb = (q_b.size() != 0) && !pa;
      e  = pa ? q_a[0] : (pb ? q_b[0] : '0);
      if (va && rdy_a) q_a.push_back({aa, da});
      if (vb && rdy_b) q_b.push_back({ab, db});
      if (pa) void'(q_a.pop_front());
      if (pb) void'(q_b.pop_front());
      if (pa || pb) begin
        m_addr = e[36:32];
        m_data = e[31:0];
        m_wen  = (m_addr != 5'd0);
        m_rr_b = pb;
        if (m_wen) rf_exp[m_addr] = m_data;
      end else begin
        m_wen = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("wen", o_wen, m_wen);
    chk("waddr", o_waddr, m_addr);
    chk("wdata", o_wdata, m_data);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    int bidx;
    for (int k = 0; k < 32; k++) begin
      rf_exp[k] = '0;
      rf_obs[k] = '0;
    end
    @(negedge clk);

    // Reset for two cycles, then readies must come up.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    chk("rst_wen", o_wen, 1'b0);
    chk("rst_waddr", o_waddr, 5'd0);
    chk("rst_wdata", o_wdata, 32'd0);
    chk("rst_busy", o_busy, 1'b0);
    idle(1);

    // Single write from A.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    chk("single_wen_n", o_wen, 1'b0);
    idle(1);
    chk("single_wen_n1", o_wen, 1'b1);
    chk("single_addr", o_waddr, 5'd5);
    idle(1);
    chk("single_wen_n2", o_wen, 1'b0);
    idle(1);
    chk("single_rf", rf_obs[5], 32'hDEADBEEF);

    // Tie: both saturated.
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    idle(6);

    // Zero-register drop from B, then a tie must go to A.
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h55);
    idle(1);
    chk("zero_wen", o_wen, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
    idle(1);
    chk("zero_tie_addr", o_waddr, 5'd9);
    idle(3);

    // Backpressure on B while A saturates.
    bidx = 0;
    for (int k = 0; k < 14; k++) begin
      step(1'b0, 1'b1, 5'd3, $urandom, bidx < 3, 5'd7, 32'(bidx + 1));
      if (acc_b) bidx++;
    end
    idle(6);
    chk("bp_stall_seen", saw_b_stall, 1'b1);
    chk("bp_count", b_log.size(), 3);
    for (int k = 0; k < 3 && k < b_log.size(); k++) chk("bp_order", b_log[k], 32'(k + 1));

    // Mid-operation reset with both FIFOs full.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 5'd12, 32'hC0 + k, 1'b1, 5'd13, 32'hD0 + k);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    idle(4);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)), $urandom);
    end
    idle(6);

    for (int k = 0; k < 32; k++) chk("rf_final", rf_obs[k], rf_exp[k]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
